// File: rtl/mdu_unit_if.sv
// mdu_unit_if: request/response bundle between the EX stage and the multiply/divide unit.
// The master side issues ops and reads HI/LO; the slave side is the MDU itself.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        flush;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, rd_sel, flush,
        input  rd_data, busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, rd_sel, flush,
        output rd_data, busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit holding the HI/LO pair.
// The result is computed at the accepting edge and held pending while a counter models
// the multi-cycle latency; HI/LO commit on the edge where the counter expires.
// Optional feature: define MDU_FLUSH_EN to let flush abort an in-flight op.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       rst_n,
    mdu_unit_if.slave mdu_if
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     res_hi_q, res_hi_d;
    logic [31:0]     res_lo_q, res_lo_d;
    logic            res_valid_q, res_valid_d;

    logic            is_md_op;
    logic            flush_act;

    logic [31:0]     a, b;
    logic [63:0]     prod_s, prod_u;
    logic [31:0]     a_mag, b_mag, div_s, div_u;
    logic [31:0]     q_mag, r_mag;
    logic [31:0]     quo_s, rem_s, quo_u, rem_u;

`ifdef MDU_FLUSH_EN
    assign flush_act = mdu_if.flush;
`else
    logic unused_flush;
    assign unused_flush = mdu_if.flush;
    assign flush_act    = 1'b0;
`endif

    assign is_md_op = (mdu_if.op >= OpMult) && (mdu_if.op <= OpDivu);

    // Arithmetic on the current operands; only consumed at the accepting edge.
    always_comb begin
        a      = mdu_if.src_a;
        b      = mdu_if.src_b;
        // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        // Signed divide through magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
        a_mag  = a[31] ? (~a + 32'd1) : a;
        b_mag  = b[31] ? (~b + 32'd1) : b;
        // Zero divisors are replaced to keep the datapath X-free; the result is discarded.
        div_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        div_u  = (b == 32'd0) ? 32'd1 : b;
        q_mag  = a_mag / div_s;
        r_mag  = a_mag % div_s;
        quo_s  = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s  = a[31] ? (~r_mag + 32'd1) : r_mag;
        quo_u  = a / div_u;
        rem_u  = a % div_u;
    end

    // Next-state logic: launch, count down, commit, or abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_valid_d = res_valid_q;

        if (flush_act) begin
            state_d     = StIdle;
            cnt_d       = '0;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mdu_if.start) begin
                        case (mdu_if.op)
                            OpMult, OpMultu: begin
                                state_d     = StRun;
                                cnt_d       = CntW'(MULT_CYCLES);
                                res_valid_d = 1'b1;
                                res_hi_d    = (mdu_if.op == OpMult) ? prod_s[63:32] : prod_u[63:32];
                                res_lo_d    = (mdu_if.op == OpMult) ? prod_s[31:0] : prod_u[31:0];
                            end
                            OpDiv, OpDivu: begin
                                state_d     = StRun;
                                cnt_d       = CntW'(DIV_CYCLES);
                                // Divide by zero still occupies the unit but never commits.
                                res_valid_d = (b != 32'd0);
                                res_hi_d    = (mdu_if.op == OpDiv) ? rem_s : rem_u;
                                res_lo_d    = (mdu_if.op == OpDiv) ? quo_s : quo_u;
                            end
                            OpMthi:  hi_d = a;
                            OpMtlo:  lo_d = a;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    // Requests arriving while running are dropped; hazard logic stalls them.
                    if (cnt_q <= CntW'(1)) begin
                        state_d     = StIdle;
                        cnt_d       = '0;
                        res_valid_d = 1'b0;
                        if (res_valid_q) begin
                            hi_d = res_hi_q;
                            lo_d = res_lo_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Outputs come straight from committed state.
    always_comb begin
        mdu_if.busy      = (state_q == StRun);
        mdu_if.stall_req = (state_q == StRun) | (mdu_if.start & is_md_op);
        mdu_if.rd_data   = mdu_if.rd_sel ? hi_q : lo_q;
        mdu_if.hi        = hi_q;
        mdu_if.lo        = lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plus random stimulus; multi-cycle results go through a scoreboard
// that a negedge monitor drains whenever busy falls.
module tb_mdu_unit;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mdu_unit_if bus ();

    mdu_unit #(
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdu_if (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          free_cycle = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    exp_t        sb_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each falling busy edge must match the oldest expected result.
    int busy_run = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL commit: got unexpected completion, required none");
                end else begin
                    e = sb_q.pop_front();
                    check("commit_hi", bus.hi, e.hi);
                    check("commit_lo", bus.lo, e.lo);
                    check("busy_len", busy_run, e.cycles);
                end
                busy_run = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) step(1);
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy after 200 cycles, required idle");
        end
    endtask

    // Issue one request for one cycle; the model decides acceptance from its own busy window.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit          busy_m, md, acc;
        longint      sp;
        logic [63:0] up;
        logic [31:0] q, r;
        exp_t        e;
        busy_m = (cyc < free_cycle);
        md     = (op >= 3'd1) && (op <= 3'd4);
        acc    = !busy_m;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.rd_sel = 1'($urandom_range(0, 1));
        #1;
        check("stall_req", {31'd0, bus.stall_req}, {31'd0, (busy_m || md)});
        check("busy_pre", {31'd0, bus.busy}, {31'd0, busy_m});
        if (acc) begin
            case (op)
                3'd1: begin
                    sp  = longint'($signed(a)) * longint'($signed(b));
                    mhi = sp[63:32];
                    mlo = sp[31:0];
                end
                3'd2: begin
                    up  = 64'(a) * 64'(b);
                    mhi = up[63:32];
                    mlo = up[31:0];
                end
                3'd3: begin
                    if (b != 0) begin
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            q = a;
                            r = 0;
                        end else begin
                            q = $signed(a) / $signed(b);
                            r = $signed(a) % $signed(b);
                        end
                        mlo = q;
                        mhi = r;
                    end
                end
                3'd4: begin
                    if (b != 0) begin
                        mlo = a / b;
                        mhi = a % b;
                    end
                end
                3'd5:    mhi = a;
                3'd6:    mlo = a;
                default: ;
            endcase
            if (md) begin
                e.hi     = mhi;
                e.lo     = mlo;
                e.cycles = (op <= 3'd2) ? MultCycles : DivCycles;
                sb_q.push_back(e);
                free_cycle = cyc + 1 + e.cycles;
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        if (acc && !md) begin
            check("hi_imm", bus.hi, mhi);
            check("lo_imm", bus.lo, mlo);
            check("busy_imm", {31'd0, bus.busy}, 32'd0);
            check("rd_data", bus.rd_data, bus.rd_sel ? mhi : mlo);
        end
    endtask

    initial begin
        logic [31:0] sh, sl, ra, rb;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.rd_sel = 1'b0;
        bus.flush  = 1'b0;
        step(2);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_rd", bus.rd_data, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Directed cases.
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle();
        issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle();
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(3'd4, 32'd7, 32'd0);
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        wait_idle();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(3'd0, 32'h5555_5555, 32'd1);
        issue(3'd7, 32'h5555_5555, 32'd1);

        // Back-to-back: second op in the first non-busy cycle.
        issue(3'd1, 32'd12345, 32'hFFFF_0001);
        for (int i = 0; i < 50 && cyc < free_cycle; i++) step(1);
        issue(3'd3, 32'd1000, 32'hFFFF_FFFD);
        wait_idle();

        // Async reset in RUN cycle 3 discards the op.
        issue(3'd1, 32'd3, 32'd4);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        sb_q.delete();
        mhi = '0;
        mlo = '0;
        free_cycle = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(12);
        check("post_rst_hi", bus.hi, 32'd0);
        check("post_rst_lo", bus.lo, 32'd0);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Flush in div cycle 4.
        issue(3'd5, 32'hCAFE_0001, 32'd0);
        issue(3'd6, 32'hCAFE_0002, 32'd0);
        sh = mhi;
        sl = mlo;
        issue(3'd3, 32'd100, 32'd7);
        step(3);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
`ifdef MDU_FLUSH_EN
        begin
            exp_t e;
            void'(sb_q.pop_back());
            e.hi     = sh;
            e.lo     = sl;
            e.cycles = 4;
            sb_q.push_back(e);
            mhi = sh;
            mlo = sl;
            free_cycle = cyc;
            check("flush_busy", {31'd0, bus.busy}, 32'd0);
        end
`else
        check("noflush_busy", {31'd0, bus.busy}, 32'd1);
`endif
        wait_idle();

        // Random traffic, including ops issued while busy.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 9);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            issue(3'($urandom_range(0, 7)), ra, rb);
            step($urandom_range(0, 6));
        end
        wait_idle();
        step(2);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
